// File: rtl/npc_lsu_pkg.sv
// npc_lsu_pkg: funct3 encodings, FSM states and access-size helper shared by the LSU
package npc_lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction
endpackage

// File: rtl/npc_lsu_align.sv
// npc_lsu_align: byte-lane placement for stores, extraction/extension for loads, legality check
module npc_lsu_align import npc_lsu_pkg::*; #(
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic              wen,
  input  logic [2:0]        funct3,
  input  logic [OW-1:0]     off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              ok,
  output logic [NB-1:0]     wmask,
  output logic [DATA_W-1:0] sdata,
  output logic [DATA_W-1:0] ldata
);
  localparam bit W64 = DATA_W == 64;
  logic [8:0] lanes;
  logic [DATA_W-1:0] sh;
  logic legal, sgn;
  assign lanes = (9'd1 << size_bytes(funct3)) - 9'd1;
  assign legal = wen ? (funct3 inside {F3_B, F3_H, F3_W} || (W64 && funct3 == F3_D))
                     : (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU} || (W64 && funct3 inside {F3_D, F3_WU}));
  assign ok = legal && (off & OW'(size_bytes(funct3) - 4'd1)) == '0;
  assign wmask = NB'(lanes[7:0]) << off;
  assign sdata = wdata << {off, 3'b000};
  assign sh = rdata >> {off, 3'b000};
  assign sgn = !funct3[2];
  assign ldata = funct3[1:0] == 2'd0 ? (sgn ? DATA_W'($signed(sh[7:0]))  : DATA_W'(sh[7:0]))  :
                 funct3[1:0] == 2'd1 ? (sgn ? DATA_W'($signed(sh[15:0])) : DATA_W'(sh[15:0])) :
                 funct3[1:0] == 2'd2 ? (sgn ? DATA_W'($signed(sh[31:0])) : DATA_W'(sh[31:0])) : sh;
endmodule

// File: rtl/npc_lsu.sv
// npc_lsu: multi-cycle load/store unit with valid/ready handshakes and a bus timeout
module npc_lsu import npc_lsu_pkg::*; #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic wen_r, err_r, idle, tmo, ok, a_wen;
  logic [2:0] f3_r, a_f3;
  logic [OW-1:0] a_off;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r, rdata_r, sdata, ldata;
  logic [NB-1:0] wmask;
  assign idle = state == IDLE;
  assign tmo = cnt == CW'(TIMEOUT - 1);
  assign a_wen = idle ? req_wen : wen_r;
  assign a_f3 = idle ? req_funct3 : f3_r;
  assign a_off = idle ? req_addr[OW-1:0] : addr_r[OW-1:0];
  npc_lsu_align #(.DATA_W(DATA_W)) u_align (
    .wen(a_wen), .funct3(a_f3), .off(a_off), .wdata(wdata_r), .rdata(mem_rdata),
    .ok(ok), .wmask(wmask), .sdata(sdata), .ldata(ldata)
  );
  // next-state: illegal requests skip the bus; the awaited event beats the timeout
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = req_valid ? (ok ? REQ : RESP) : IDLE;
      REQ:     nxt = mem_ready ? (wen_r ? RESP : WAIT) : (tmo ? RESP : REQ);
      WAIT:    nxt = (mem_rvalid || tmo) ? RESP : WAIT;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // state, timeout counter and captured access fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      wen_r <= 1'b0;
      err_r <= 1'b0;
      f3_r <= '0;
      addr_r <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
    end else begin
      state <= nxt;
      cnt <= (state == REQ || state == WAIT) ? cnt + 1'b1 : '0;
      if (idle && req_valid) begin
        wen_r <= req_wen;
        f3_r <= req_funct3;
        addr_r <= req_addr;
        wdata_r <= req_wdata;
        err_r <= !ok;
        rdata_r <= '0;
      end
      if (tmo && ((state == REQ && !mem_ready) || (state == WAIT && !mem_rvalid))) err_r <= 1'b1;
      if (state == WAIT && mem_rvalid) rdata_r <= ldata;
    end
  end
  assign req_ready = idle;
  assign resp_valid = state == RESP;
  assign resp_rdata = resp_valid ? rdata_r : '0;
  assign resp_err = resp_valid && err_r;
  assign mem_valid = state == REQ;
  assign mem_wen = mem_valid && wen_r;
  assign mem_addr = {addr_r[ADDR_W-1:OW], OW'(0)};
  assign mem_wmask = mem_wen ? wmask : '0;
  assign mem_wdata = mem_wen ? sdata : '0;
endmodule

// File: tb/tb_npc_lsu.sv
// tb_npc_lsu: scoreboard bench for npc_lsu at DATA_W=32 (TIMEOUT=4) and DATA_W=64
module tb_npc_lsu;
  import npc_lsu_pkg::*;
  typedef struct { logic [63:0] rdata; logic err; int cyc; } exp_t;
  exp_t q32[$], q64[$];
  exp_t e32, e64;
  int checks = 0, fails = 0, cyc = 0, mv_cnt = 0;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_wen = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
  logic req_ready, resp_valid, resp_err, mem_valid, mem_wen, mem_ready, mem_rvalid;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_wmask;
  logic rdy_en = 1, rv_auto = 1, rv_force = 0, rv_q = 0;
  logic d_req_valid = 0, d_req_wen = 0;
  logic [2:0] d_req_funct3 = 0;
  logic [31:0] d_req_addr = 0, d_mem_addr;
  logic [63:0] d_req_wdata = 0, d_mem_rdata = 0, d_resp_rdata, d_mem_wdata;
  logic d_req_ready, d_resp_valid, d_resp_err, d_mem_valid, d_mem_wen, d_rv_q = 0;
  logic [7:0] d_mem_wmask;

  npc_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  npc_lsu #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(8)) dut64 (
    .clk(clk), .rst(rst), .req_valid(d_req_valid), .req_ready(d_req_ready), .req_wen(d_req_wen),
    .req_funct3(d_req_funct3), .req_addr(d_req_addr), .req_wdata(d_req_wdata), .resp_valid(d_resp_valid),
    .resp_rdata(d_resp_rdata), .resp_err(d_resp_err), .mem_valid(d_mem_valid), .mem_ready(1'b1),
    .mem_wen(d_mem_wen), .mem_addr(d_mem_addr), .mem_wdata(d_mem_wdata), .mem_wmask(d_mem_wmask),
    .mem_rvalid(d_rv_q), .mem_rdata(d_mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_ready = rdy_en;
  assign mem_rvalid = rv_q | rv_force;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rv_q <= rv_auto && mem_valid && mem_ready && !mem_wen;
    d_rv_q <= d_mem_valid && !d_mem_wen;
  end
  always @(negedge clk) if (mem_valid) mv_cnt++;

  always @(negedge clk) if (!rst) begin
    checks++;
    if (resp_valid) begin
      if (q32.size() == 0) begin
        fails++;
        $display("FAIL resp32_unexpected rdata=%h err=%b cyc=%0d", resp_rdata, resp_err, cyc);
      end else begin
        e32 = q32.pop_front();
        if (resp_rdata !== e32.rdata[31:0] || resp_err !== e32.err || cyc !== e32.cyc) begin
          fails++;
          $display("FAIL resp32 got rdata=%h err=%b cyc=%0d expected rdata=%h err=%b cyc=%0d",
                   resp_rdata, resp_err, cyc, e32.rdata[31:0], e32.err, e32.cyc);
        end
      end
    end else if (resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
      fails++;
      $display("FAIL resp32_idle got rdata=%h err=%b expected 0 0", resp_rdata, resp_err);
    end
  end

  always @(negedge clk) if (!rst && d_resp_valid) begin
    checks++;
    if (q64.size() == 0) begin
      fails++;
      $display("FAIL resp64_unexpected rdata=%h err=%b", d_resp_rdata, d_resp_err);
    end else begin
      e64 = q64.pop_front();
      if (d_resp_rdata !== e64.rdata || d_resp_err !== e64.err || cyc !== e64.cyc) begin
        fails++;
        $display("FAIL resp64 got rdata=%h err=%b cyc=%0d expected rdata=%h err=%b cyc=%0d",
                 d_resp_rdata, d_resp_err, cyc, e64.rdata, e64.err, e64.cyc);
      end
    end
  end

  task automatic issue32(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         input int lat, input bit push);
    exp_t x;
    req_valid = 1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    if (push) begin x.rdata = {32'd0, er}; x.err = ee; x.cyc = cyc + lat; q32.push_back(x); end
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic issue64(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [63:0] wd, input logic [63:0] er, input logic ee, input int lat);
    exp_t x;
    d_req_valid = 1; d_req_wen = wen; d_req_funct3 = f3; d_req_addr = addr; d_req_wdata = wd;
    x.rdata = er; x.err = ee; x.cyc = cyc + lat; q64.push_back(x);
    @(negedge clk);
    d_req_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() + q64.size() != 0 || req_ready !== 1'b1 || d_req_ready !== 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q32.size() + q64.size() != 0 || req_ready !== 1'b1 || d_req_ready !== 1'b1) begin
      fails++;
      $display("FAIL drain got pending=%0d/%0d ready=%b/%b expected 0/0 1/1",
               q32.size(), q64.size(), req_ready, d_req_ready);
      q32.delete();
      q64.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_req_ready got=%b expected=1", req_ready); end
    checks++;
    if ({resp_valid, resp_err, mem_valid, mem_wen} !== 4'b0) begin
      fails++; $display("FAIL rst_flags got=%b expected=0000", {resp_valid, resp_err, mem_valid, mem_wen});
    end
    checks++;
    if (resp_rdata !== 32'd0 || mem_wmask !== 4'd0) begin
      fails++; $display("FAIL rst_data got rdata=%h wmask=%b expected 0 0", resp_rdata, mem_wmask);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_load();
    logic [2:0] f3s [7] = '{F3_H, F3_HU, F3_W, F3_BU, F3_B, F3_H, F3_B};
    logic [31:0] ads [7] = '{32'h80000002, 32'h80000002, 32'h80000000, 32'h80000001, 32'h80000000, 32'h80000000, 32'h80000002};
    logic [31:0] exs [7] = '{32'hFFFF80FF, 32'h000080FF, 32'h80FF1234, 32'h00000012, 32'h00000034, 32'h00001234, 32'hFFFFFFFF};
    rdy_en = 1; rv_auto = 1; mem_rdata = 32'h80FF1234;
    issue32(0, F3_B, 32'h80000003, 0, 32'hFFFFFF80, 0, 3, 1);
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h80000000 || mem_wen !== 1'b0 || mem_wmask !== 4'd0) begin
      fails++;
      $display("FAIL lb_bus got valid=%b addr=%h wen=%b wmask=%b expected 1 80000000 0 0000",
               mem_valid, mem_addr, mem_wen, mem_wmask);
    end
    drain();
    for (int i = 0; i < 7; i++) begin
      issue32(0, f3s[i], ads[i], 0, exs[i], 0, 3, 1);
      drain();
    end
  endtask

  task automatic test_store();
    logic [2:0] f3s [5] = '{F3_H, F3_B, F3_B, F3_W, F3_H};
    logic [31:0] ads [5] = '{32'h80000002, 32'h80000001, 32'h80000003, 32'h80000000, 32'h80000000};
    logic [31:0] wds [5] = '{32'h0000ABCD, 32'h12345678, 32'h000000AA, 32'hDEADBEEF, 32'h1234ABCD};
    logic [3:0]  wms [5] = '{4'b1100, 4'b0010, 4'b1000, 4'b1111, 4'b0011};
    logic [31:0] mds [5] = '{32'hABCD0000, 32'h34567800, 32'hAA000000, 32'hDEADBEEF, 32'h1234ABCD};
    for (int i = 0; i < 5; i++) begin
      issue32(1, f3s[i], ads[i], wds[i], 0, 0, 2, 1);
      checks++;
      if (mem_valid !== 1'b1 || mem_wen !== 1'b1 || mem_wmask !== wms[i] || mem_wdata !== mds[i] || mem_addr !== {ads[i][31:2], 2'b00}) begin
        fails++;
        $display("FAIL store_bus%0d got valid=%b wen=%b wmask=%b wdata=%h addr=%h expected 1 1 %b %h %h",
                 i, mem_valid, mem_wen, mem_wmask, mem_wdata, mem_addr, wms[i], mds[i], {ads[i][31:2], 2'b00});
      end
      drain();
    end
  endtask

  task automatic test_errors();
    logic wens [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 1};
    logic [2:0] f3s [9] = '{F3_W, 3'b111, F3_H, F3_H, F3_W, F3_D, F3_D, F3_WU, F3_BU};
    logic [31:0] ads [9] = '{32'h80000001, 32'h80000000, 32'h80000003, 32'h80000001, 32'h80000002,
                             32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
    int m = mv_cnt;
    mem_rdata = 32'h55AA55AA;
    for (int i = 0; i < 9; i++) begin
      issue32(wens[i], f3s[i], ads[i], 32'hFFFFFFFF, 0, 1, 1, 1);
      checks++;
      if (mem_valid !== 1'b0) begin fails++; $display("FAIL err_bus%0d got mem_valid=%b expected=0", i, mem_valid); end
      drain();
    end
    checks++;
    if (mv_cnt !== m) begin fails++; $display("FAIL err_no_mem got=%0d expected=%0d", mv_cnt, m); end
  endtask

  task automatic test_timeout();
    int m = mv_cnt;
    rdy_en = 0;
    issue32(0, F3_W, 32'h80000010, 0, 0, 1, 5, 1);
    drain();
    checks++;
    if (mv_cnt - m !== 4) begin fails++; $display("FAIL tmo_req_cycles got=%0d expected=4", mv_cnt - m); end
    rdy_en = 1; rv_auto = 0;
    issue32(0, F3_W, 32'h80000010, 0, 0, 1, 5, 1);
    drain();
    mem_rdata = 32'h13579BDF;
    issue32(0, F3_W, 32'h80000020, 0, 32'h13579BDF, 0, 5, 1);
    repeat (3) @(negedge clk);
    rv_force = 1;
    @(negedge clk);
    rv_force = 0;
    drain();
    rv_auto = 1; mem_rdata = 32'h80FF1234;
    issue32(0, F3_W, 32'h80000004, 0, 32'h80FF1234, 0, 3, 1);
    drain();
  endtask

  task automatic test_reset_mid();
    rv_auto = 0; rdy_en = 1;
    issue32(0, F3_W, 32'h80000000, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || mem_valid !== 1'b0) begin
      fails++; $display("FAIL mid_wait got ready=%b mem_valid=%b expected 0 0", req_ready, mem_valid);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL mid_ready got=%b expected=1", req_ready); end
    rv_force = 1;
    @(negedge clk);
    rv_force = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (resp_valid !== 1'b0) begin fails++; $display("FAIL mid_noresp got=%b expected=0", resp_valid); end
      @(negedge clk);
    end
    rv_auto = 1; mem_rdata = 32'h00C30000;
    issue32(0, F3_BU, 32'h80000002, 0, 32'h000000C3, 0, 3, 1);
    drain();
  endtask

  task automatic test_dw64();
    d_mem_rdata = 64'hF0000001_00000000;
    issue64(0, F3_WU, 32'h80000004, 0, 64'h00000000_F0000001, 0, 3);
    drain();
    issue64(0, F3_W, 32'h80000004, 0, 64'hFFFFFFFF_F0000001, 0, 3);
    drain();
    issue64(0, F3_D, 32'h80000008, 0, 64'hF0000001_00000000, 0, 3);
    drain();
    issue64(0, F3_D, 32'h80000004, 0, 0, 1, 1);
    drain();
    issue64(1, F3_D, 32'h80000000, 64'h01234567_89ABCDEF, 0, 0, 2);
    checks++;
    if (d_mem_wmask !== 8'hFF || d_mem_wdata !== 64'h01234567_89ABCDEF || d_mem_wen !== 1'b1) begin
      fails++; $display("FAIL sd_bus got wmask=%h wdata=%h wen=%b expected ff 0123456789abcdef 1", d_mem_wmask, d_mem_wdata, d_mem_wen);
    end
    drain();
    issue64(1, F3_W, 32'h8000000C, 64'h00000000_CAFEF00D, 0, 0, 2);
    checks++;
    if (d_mem_wmask !== 8'hF0 || d_mem_wdata !== 64'hCAFEF00D_00000000 || d_mem_addr !== 32'h80000008) begin
      fails++; $display("FAIL sw64_bus got wmask=%h wdata=%h addr=%h expected f0 cafef00d00000000 80000008", d_mem_wmask, d_mem_wdata, d_mem_addr);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_dw64();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end
endmodule
